duty_slew_ctrl: RTL and testbench
=================================

# duty_slew_ctrl

Upstream feeder for the PWM core: accepts a target duty cycle (percent, 0-100) over a valid/ready handshake and slews its registered 7-bit duty output toward that target in fixed steps at a programmable tick rate. Its duty output connects directly to the PWM core's 7-bit duty-cycle input. Abrupt duty changes therefore never reach the PWM stage. Supports freeze (hold) and reports ramp completion.

## Interface
- STEP_PERIOD, 100: clock cycles per slew tick (≥2)
- STEP, 1: duty increment per tick (1..100)
- MAX_DUTY, 100: upper clamp for accepted targets (≤127)

- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; one clock domain only
- io_target_valid  in  1  target offered
- io_target_ready  out  1  block can accept a target
- io_target_bits  in  7  requested duty, percent
- io_hold  in  1  freeze tick counter and duty
- io_dutyCycle  out  7  registered duty to PWM core
- io_busy  out  1  ramp in progress
- io_done  out  1  one-cycle pulse on ramp completion

## Operation
- States: IDLE, RAMP_UP, RAMP_DOWN. io_target_ready = (state == IDLE). io_busy = (state != IDLE).
- Accept: io_target_valid && io_target_ready at a rising edge. Latch tgt = min(io_target_bits, MAX_DUTY). Clear tick counter.
- Transition at the accept edge:
  - tgt > duty → RAMP_UP
  - tgt < duty → RAMP_DOWN
  - tgt == duty → stay IDLE; io_done pulses next cycle
- Tick counter runs 0..STEP_PERIOD-1 only in ramp states when io_hold=0. It wraps to 0 at STEP_PERIOD-1; that edge is a tick.
- On a tick in RAMP_UP:
  - tgt-duty ≤ STEP → duty=tgt, go IDLE, io_done=1 for one cycle
  - otherwise → duty += STEP
- RAMP_DOWN mirrors RAMP_UP. Duty never overshoots tgt and never leaves 0..MAX_DUTY. Arithmetic uses 8-bit intermediates; no 7-bit wrap.
- io_hold=1: counter and duty frozen, state unchanged, io_done suppressed. IDLE handshake is unaffected by hold.
- io_target_valid while busy: ignored (ready=0). A target is never queued.

## Timing
- Reset values:
  - io_dutyCycle=0, io_busy=0, io_done=0, io_target_ready=1
  - state IDLE, counter 0, tgt 0
- Reset is asynchronous. Asserting it mid-ramp immediately forces all reset values; the ramp is abandoned.
- Accept at edge k → io_busy=1 from k. The first duty change is visible after edge k+STEP_PERIOD. Each later change follows STEP_PERIOD edges after the previous one, provided hold stays low.
- Ramp of distance d takes ceil(d/STEP) ticks. Final duty and io_done=1 appear at the same edge. io_busy drops and io_target_ready rises at that edge.
- A new target is acceptable in the cycle io_done is high.
- Hold asserted for h cycles during a ramp delays all remaining steps by exactly h cycles.
- io_dutyCycle changes only on tick edges and reset; it is glitch-free (registered).

## Test plan
- Reset: reset=1 for 2 cycles → io_dutyCycle=0, io_busy=0, io_done=0, io_target_ready=1. After release, outputs hold with no target offered.
- Ramp up (STEP_PERIOD=100, STEP=1): accept target 10 from duty 0 → duty increments every 100 cycles. Duty reaches 10 at 1000 cycles after accept, with io_done high for exactly one cycle and io_busy then 0.
- Ramp down, non-multiple step (STEP=3): from duty 10, accept 0 → duty sequence 7, 4, 1, 0 (4 ticks). io_done is pulsed once and there is no underflow.
- Clamp/equal: offer 120 → ramp ends at 100. Then offer 100 → no ramp, io_busy stays 0, io_done pulses next cycle.
- Hold and busy-ignore: during ramp 0→10, hold for 250 cycles → completion delayed by exactly 250 cycles. A valid target 50 offered mid-ramp is not accepted (ready=0), and the final duty is 10.
- Reset mid-ramp: assert reset asynchronously at duty 5 of ramp 0→10 → duty=0 and IDLE immediately. A new target 20 is accepted after release and ramps from 0.

Source files
------------

// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl
//   Feeds the PWM core's 7-bit duty input. A target duty (percent) is
//   accepted over a valid/ready handshake, clamped to MAX_DUTY, and the
//   registered duty output walks toward it by STEP once every STEP_PERIOD
//   clocks. This keeps abrupt duty changes away from the PWM stage.
//
// Parameters
//   STEP_PERIOD : clocks per slew tick (>= 2)
//   STEP        : duty change per tick (1..100)
//   MAX_DUTY    : upper clamp for accepted targets (<= 127)
//
// Ports
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-high
//   io_target_valid in   target offered
//   io_target_ready out  high in IDLE only
//   io_target_bits  in   requested duty, percent
//   io_hold         in   freezes tick counter and duty during a ramp
//   io_dutyCycle    out  registered duty to the PWM core
//   io_busy         out  ramp in progress
//   io_done         out  one-cycle pulse when a ramp (or equal target) completes
//   o_dbg_state     out  FSM state: 0 IDLE, 1 RAMP_UP, 2 RAMP_DOWN
//
// Handshake: a target transfers on a rising edge where io_target_valid and
// io_target_ready are both high. Ready depends only on the FSM state, never
// on valid. Targets offered while busy are not taken and are not queued.

module duty_slew_ctrl #(
  parameter int STEP_PERIOD = 100,
  parameter int STEP        = 1,
  parameter int MAX_DUTY    = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_target_valid,
  output logic       io_target_ready,
  input  logic [6:0] io_target_bits,
  input  logic       io_hold,
  output logic [6:0] io_dutyCycle,
  output logic       io_busy,
  output logic       io_done,
  output logic [1:0] o_dbg_state
);

  localparam int CW = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_PERIOD - 1);
  localparam logic [6:0]    MAX7     = 7'(MAX_DUTY);
  localparam logic [6:0]    STEP7    = 7'(STEP);
  localparam logic [7:0]    STEP8    = 8'(STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_tgt;
  logic [6:0]    r_duty;
  logic          r_done;

  logic [6:0] w_clamped;
  logic [7:0] w_up_gap;
  logic [7:0] w_dn_gap;
  logic       w_tick;

  assign w_clamped = (io_target_bits > MAX7) ? MAX7 : io_target_bits;
  // Remaining distance, computed one bit wider so it can never wrap.
  assign w_up_gap  = {1'b0, r_tgt} - {1'b0, r_duty};
  assign w_dn_gap  = {1'b0, r_duty} - {1'b0, r_tgt};
  assign w_tick    = !io_hold && (r_cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_duty  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_target_valid) begin
            r_tgt <= w_clamped;
            r_cnt <= '0;
            if (w_clamped > r_duty)      r_state <= RAMP_UP;
            else if (w_clamped < r_duty) r_state <= RAMP_DOWN;
            else                         r_done  <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (!io_hold) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
          if (w_tick) begin
            if (w_up_gap <= STEP8) begin
              r_duty  <= r_tgt;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              // Gap exceeds STEP here, so the sum stays below r_tgt.
              r_duty <= r_duty + STEP7;
            end
          end
        end
        RAMP_DOWN: begin
          if (!io_hold) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
          if (w_tick) begin
            if (w_dn_gap <= STEP8) begin
              r_duty  <= r_tgt;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              // Gap exceeds STEP here, so the difference stays above r_tgt.
              r_duty <= r_duty - STEP7;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_target_ready = (r_state == IDLE);
  assign io_busy         = (r_state != IDLE);
  assign io_dutyCycle    = r_duty;
  assign io_done         = r_done;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Bench for duty_slew_ctrl. Unit 0 uses the default parameters
// (STEP_PERIOD=100, STEP=1); unit 1 uses STEP_PERIOD=4, STEP=3 for the
// non-multiple ramp-down case. Every duty change or done pulse of either
// unit is an event; expected events {unit, done, duty, cycle} are queued by
// the driver and popped by the monitor.

module tb_duty_slew_ctrl;

  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       rst     [2];
  logic       tv      [2];
  logic [6:0] tb_bits [2];
  logic       hold    [2];
  logic       rdy     [2];
  logic       busy    [2];
  logic       done    [2];
  logic [6:0] duty    [2];
  logic [1:0] st      [2];

  duty_slew_ctrl #(.STEP_PERIOD(100), .STEP(1), .MAX_DUTY(100)) u_dut0 (
    .clock(clock), .reset(rst[0]), .io_target_valid(tv[0]),
    .io_target_ready(rdy[0]), .io_target_bits(tb_bits[0]), .io_hold(hold[0]),
    .io_dutyCycle(duty[0]), .io_busy(busy[0]), .io_done(done[0]),
    .o_dbg_state(st[0])
  );

  duty_slew_ctrl #(.STEP_PERIOD(4), .STEP(3), .MAX_DUTY(100)) u_dut1 (
    .clock(clock), .reset(rst[1]), .io_target_valid(tv[1]),
    .io_target_ready(rdy[1]), .io_target_bits(tb_bits[1]), .io_hold(hold[1]),
    .io_dutyCycle(duty[1]), .io_busy(busy[1]), .io_done(done[1]),
    .o_dbg_state(st[1])
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errs    = 0;

  function automatic logic [W-1:0] mk(input int u, input logic d, input logic [6:0] v, input int c);
    logic [31:0] cc;
    logic [31:0] uu;
    cc = c;
    uu = u;
    return {uu[0], d, v, cc[23:0]};
  endfunction

  // Expected ramp events; ticks after the hold start are shifted by hl.
  function automatic void push_ramp(input int u, input int from, input int to, input int k,
                                    input int sp, input int step, input int hs, input int hl);
    int d;
    int i;
    int t;
    logic [31:0] dv;
    d = from;
    i = 0;
    if (from == to) exp_q.push_back(mk(u, 1'b1, 7'(from), k));
    while (d != to) begin
      i++;
      if (to > d) d = (to - d <= step) ? to : d + step;
      else        d = (d - to <= step) ? to : d - step;
      t = k + sp * i;
      if (hl > 0 && t > k + hs) t += hl;
      dv = d;
      exp_q.push_back(mk(u, (d == to), dv[6:0], t));
    end
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [6:0]   prev [2];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  initial begin
    prev[0] = 7'd0;
    prev[1] = 7'd0;
  end

  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (duty[u] !== prev[u] || done[u] !== 1'b0) begin
        mon_got = mk(u, done[u], duty[u], cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL event: unit %0d duty=%0d done=%0d at cyc %0d, expected no event",
                   u, duty[u], done[u], cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_exp !== mon_got) begin
            errs++;
            $display("FAIL event: got unit %0d done=%0d duty=%0d cyc=%0d, expected unit %0d done=%0d duty=%0d cyc=%0d",
                     mon_got[32], mon_got[31], mon_got[30:24], mon_got[23:0],
                     mon_exp[32], mon_exp[31], mon_exp[30:24], mon_exp[23:0]);
          end
        end
      end
      prev[u] = duty[u];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Called at a negedge; the target transfers on the following posedge.
  task automatic send(input int u, input logic [6:0] t, input logic exp_rdy);
    tb_bits[u] = t;
    tv[u]      = 1'b1;
    chk("ready_at_offer", rdy[u], exp_rdy);
    @(posedge clock);
    @(negedge clock);
    tv[u] = 1'b0;
  endtask

  // Called at a negedge; reset is raised between edges and checked at once.
  task automatic async_reset(input int u, input logic duty_nonzero);
    if (duty_nonzero) exp_q.push_back(mk(u, 1'b0, 7'd0, cyc + 1));
    #2;
    rst[u] = 1'b1;
    #1;
    chk("async_rst_duty", duty[u], 0);
    chk("async_rst_busy", busy[u], 0);
    chk("async_rst_ready", rdy[u], 1);
    chk("async_rst_state", st[u], 0);
    @(negedge clock);
    @(negedge clock);
    rst[u] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int k;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]     = 1'b1;
      tv[u]      = 1'b0;
      tb_bits[u] = 7'd0;
      hold[u]    = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      chk("reset_duty", duty[u], 0);
      chk("reset_busy", busy[u], 0);
      chk("reset_done", done[u], 0);
      chk("reset_ready", rdy[u], 1);
      chk("reset_state", st[u], 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_reset_duty", duty[0], 0);
    chk("post_reset_busy", busy[0], 0);
    chk("post_reset_ready", rdy[0], 1);

    // Ramp up 0 -> 10, one step per 100 cycles.
    k = cyc + 1;
    push_ramp(0, 0, 10, k, 100, 1, 0, 0);
    send(0, 7'd10, 1'b1);
    chk("up_busy_at_accept", busy[0], 1);
    chk("up_ready_at_accept", rdy[0], 0);
    wait_until(k + 99);
    chk("up_duty_before_first_tick", duty[0], 0);
    wait_until(k + 999);
    chk("up_duty_before_last", duty[0], 9);
    chk("up_busy_before_last", busy[0], 1);
    wait_until(k + 1000);
    chk("up_duty_final", duty[0], 10);
    chk("up_busy_final", busy[0], 0);
    chk("up_ready_final", rdy[0], 1);

    // Target 120 clamps to 100; offered in the done cycle of the last ramp.
    k = cyc + 1;
    push_ramp(0, 10, 100, k, 100, 1, 0, 0);
    send(0, 7'd120, 1'b1);
    wait_until(k + 9000);
    chk("clamp_duty", duty[0], 100);
    chk("clamp_busy", busy[0], 0);

    // Equal target: no ramp, done pulses right after the accept edge.
    k = cyc + 1;
    push_ramp(0, 100, 100, k, 100, 1, 0, 0);
    send(0, 7'd100, 1'b1);
    chk("equal_busy", busy[0], 0);
    chk("equal_ready", rdy[0], 1);
    @(negedge clock);
    chk("equal_done_dropped", done[0], 0);
    chk("equal_duty", duty[0], 100);

    async_reset(0, 1'b1);

    // Hold for 250 cycles mid-ramp; a target offered while busy is ignored.
    k = cyc + 1;
    push_ramp(0, 0, 10, k, 100, 1, 150, 250);
    send(0, 7'd10, 1'b1);
    wait_until(k + 60);
    tb_bits[0] = 7'd50;
    tv[0]      = 1'b1;
    chk("busy_ignore_ready", rdy[0], 0);
    wait_until(k + 120);
    chk("busy_ignore_ready_late", rdy[0], 0);
    chk("busy_ignore_duty", duty[0], 1);
    tv[0] = 1'b0;
    wait_until(k + 150);
    hold[0] = 1'b1;
    wait_until(k + 300);
    chk("hold_duty_frozen", duty[0], 1);
    chk("hold_busy", busy[0], 1);
    wait_until(k + 400);
    hold[0] = 1'b0;
    wait_until(k + 1249);
    chk("hold_duty_before_last", duty[0], 9);
    wait_until(k + 1250);
    chk("hold_duty_final", duty[0], 10);
    chk("hold_busy_final", busy[0], 0);

    async_reset(0, 1'b1);

    // Reset in the middle of a ramp at duty 5, then a fresh ramp from 0.
    k = cyc + 1;
    for (int i = 1; i <= 5; i++) exp_q.push_back(mk(0, 1'b0, 7'(i), k + 100 * i));
    send(0, 7'd10, 1'b1);
    wait_until(k + 520);
    chk("mid_ramp_duty", duty[0], 5);
    async_reset(0, 1'b1);
    k = cyc + 1;
    push_ramp(0, 0, 20, k, 100, 1, 0, 0);
    send(0, 7'd20, 1'b1);
    wait_until(k + 2000);
    chk("after_reset_duty", duty[0], 20);
    chk("after_reset_busy", busy[0], 0);

    // Unit 1: STEP=3, STEP_PERIOD=4. Up 0 -> 10, then down to 0 in the done cycle.
    k = cyc + 1;
    push_ramp(1, 0, 10, k, 4, 3, 0, 0);
    send(1, 7'd10, 1'b1);
    wait_until(k + 16);
    chk("s3_up_duty", duty[1], 10);
    chk("s3_up_done", done[1], 1);
    k = cyc + 1;
    push_ramp(1, 10, 0, k, 4, 3, 0, 0);
    send(1, 7'd0, 1'b1);
    chk("s3_down_busy", busy[1], 1);
    wait_until(k + 15);
    chk("s3_down_before_last", duty[1], 1);
    wait_until(k + 16);
    chk("s3_down_duty", duty[1], 0);
    chk("s3_down_busy_end", busy[1], 0);
    repeat (3) @(negedge clock);

    chk("events_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
